spatz_vrf_reader: RTL and testbench
===================================

Name: spatz_vrf_reader

Overview:
- Requester-side read initiator for one VRF read port (VFU vs1/vs2/vd, LSU or slide operand).
- Turns one operand request (start vreg, start word, word count) into a stream of consecutive VRF word reads.
- Tolerates bank-conflict stalls, where rvalid is withheld by the VRF arbiter.
- Buffers returned words in a small FIFO and hands them to the consuming unit over valid/ready, tagging the last word.

Parameters:
- NrVRegs, 32, number of architectural vector registers (power of two).
- WordsPerVReg, 4, VRF words per register (power of two, ≥1).
- DataWidth, 128, VRF word width in bits.
- FifoDepth, 2, return-buffer entries (≥1).
- AddrWidth, $clog2(NrVRegs)+$clog2(WordsPerVReg), derived; VRF word address = {vreg, word}.
- LenWidth, AddrWidth+1, derived; width of the word count.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  operand request valid.
- req_ready_o  out  1  request accepted when high together with valid.
- req_vreg_i  in  $clog2(NrVRegs)  start register.
- req_word_i  in  $clog2(WordsPerVReg)  start word within the register.
- req_len_i  in  LenWidth  number of words to read.
- kill_i  in  1  abort current operand.
- raddr_o  out  AddrWidth  VRF read address.
- re_o  out  1  VRF read enable.
- rdata_i  in  DataWidth  VRF read data, valid in the same cycle as rvalid_i.
- rvalid_i  in  1  read granted this cycle.
- data_o  out  DataWidth  operand word.
- last_o  out  1  data_o is the final word of the operand.
- valid_o  out  1  operand word valid.
- ready_i  in  1  consumer accepts the word.
- busy_o  out  1  state ≠ IDLE, or FIFO not empty.
- conflict_cnt_o  out  32  stall statistics (see Optional Feature).

Behaviour:
- Reset (rst_i sampled high at a clock edge): state=IDLE, FIFO empty, counters 0.
  - Output values: req_ready_o=1, re_o=0, raddr_o=0, valid_o=0, last_o=0, data_o=0, busy_o=0, conflict_cnt_o=0.
  - Reset mid-operation drops all pending reads and buffered data; no further re_o.
- States: IDLE, READ.
- IDLE:
  - req_ready_o=1.
  - Handshake with req_len_i>0: latch addr={req_vreg_i,req_word_i} and rem=req_len_i, go to READ.
  - Handshake with req_len_i=0: accepted, no reads, no output, stay IDLE.
- READ:
  - req_ready_o=0.
  - raddr_o=addr.
  - re_o=1 iff FIFO occupancy after this cycle's pop is < FifoDepth; equivalently count<FifoDepth, or count==FifoDepth with a pop this cycle.
  - re_o && rvalid_i: push {rdata_i, last=(rem==1)}; addr<=addr+1 modulo 2^AddrWidth; rem<=rem-1.
    - Word carry moves to the next register (LMUL grouping).
    - Address past v(NrVRegs-1) wraps to v0 word 0.
  - re_o && !rvalid_i: conflict stall. addr and rem hold; raddr_o stays stable; no push.
  - After the push with rem==1: go to IDLE in the next cycle. A new request may be accepted while the FIFO still drains.
- FIFO:
  - Registered storage.
  - Word pushed in cycle t is visible on data_o/valid_o at t+1 at the earliest.
  - Pop on valid_o && ready_i.
  - Simultaneous push and pop keeps the count.
  - Order preserved; never overflows or underflows.
  - data_o holds stable while valid_o && !ready_i.
- kill_i (highest priority after reset): next cycle state=IDLE and FIFO empty.
  - The push and pop of the kill cycle are discarded.
  - re_o may be high in the kill cycle; its grant is ignored.
- req_valid_i while in READ: ignored (not accepted).
- last_o valid only with valid_o; it is exactly one word per accepted request with len>0.

Optional Feature:
- Macro: SPATZ_VRF_READER_STATS_EN.
- Defined:
  - 32-bit counter increments on each cycle with re_o && !rvalid_i.
  - Saturates at 2^32-1.
  - Cleared by reset only; kill does not clear it.
  - Drives conflict_cnt_o.
- Undefined: no counter logic; conflict_cnt_o tied to 0.

Decomposition:
- spatz_pkg additions:
  - vrf_reader_state_e (IDLE, READ).
  - vrf_word_addr_t (AddrWidth).
  - vrf_len_t (LenWidth).
  - Default constants VRF_READER_FIFO_DEPTH=2 and VRF_WORDS_PER_VREG.
- One sub-module: spatz_vrf_reader_fifo.
  - Parametric depth/width; push, pop, flush; full/empty/count.
  - Stores {last, data}.
- FSM, address and remaining-count logic stay in the top module.

Test Plan:
- Contiguous read:
  - Stimulus: vreg=3, word=0, len=4; rvalid_i=1 and ready_i=1 throughout.
  - raddr_o=0x0C,0x0D,0x0E,0x0F in consecutive cycles.
  - 4 words out in order, each one cycle after its grant; last_o only on the 4th.
  - req_ready_o back high the cycle after the last grant.
- Register crossing and wrap:
  - vreg=3, word=2, len=4 → 0x0E,0x0F,0x10,0x11.
  - vreg=31, word=3, len=2 → 0x7F,0x00.
- Conflict stalls:
  - Stimulus: len=4, rvalid_i low for 3 cycles after the 2nd grant.
  - raddr_o holds 0x0E for 3 cycles; no duplicate or missing words.
  - With the macro: conflict_cnt_o=3. Without it: 0.
- Backpressure:
  - Stimulus: ready_i=0, FifoDepth=2, len=4.
  - Two grants, then re_o=0.
  - Raising ready_i for one cycle: pop and re-issue in the same cycle.
  - data_o stable while stalled.
- Kill and zero length:
  - kill_i after 2 grants of a len=4 request → next cycle valid_o=0, re_o=0, req_ready_o=1, busy_o=0.
  - A len=0 request is accepted in 1 cycle with no re_o.
- Reset mid-operation:
  - rst_i high during READ with 2 words buffered → all outputs at reset values next cycle.
  - A following request behaves as in the contiguous-read test.

Source files
------------

// File: rtl/spatz_vrf_reader_pkg.sv
// Shared types and default sizing for the VRF read initiator.
package spatz_vrf_reader_pkg;

  localparam int unsigned VRF_NR_VREGS          = 32;
  localparam int unsigned VRF_WORDS_PER_VREG    = 4;
  localparam int unsigned VRF_READER_FIFO_DEPTH = 2;
  localparam int unsigned VRF_WORD_ADDR_W       = $clog2(VRF_NR_VREGS) + $clog2(VRF_WORDS_PER_VREG);
  localparam int unsigned VRF_LEN_W             = VRF_WORD_ADDR_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } vrf_reader_state_e;

  typedef logic [VRF_WORD_ADDR_W-1:0] vrf_word_addr_t;
  typedef logic [VRF_LEN_W-1:0]       vrf_len_t;

endpackage

// File: rtl/spatz_vrf_reader_fifo.sv
// Return buffer for VRF read data: registered storage, flushable, output masked to 0 when empty.
module spatz_vrf_reader_fifo #(
  parameter  int unsigned Depth = 2,
  parameter  int unsigned Width = 8,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rptr_q];

  // A push into a full buffer is legal only when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
    if (do_pop)  rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i && !rst_i) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/spatz_vrf_reader.sv
// Requester-side VRF read initiator: one operand request becomes a stream of word reads.
// Optional conflict-stall counter enabled by defining SPATZ_VRF_READER_STATS_EN.
module spatz_vrf_reader
  import spatz_vrf_reader_pkg::*;
#(
  parameter int unsigned NrVRegs      = VRF_NR_VREGS,
  parameter int unsigned WordsPerVReg = VRF_WORDS_PER_VREG,
  parameter int unsigned DataWidth    = 128,
  parameter int unsigned FifoDepth    = VRF_READER_FIFO_DEPTH,
  parameter int unsigned AddrWidth    = $clog2(NrVRegs) + $clog2(WordsPerVReg),
  parameter int unsigned LenWidth     = AddrWidth + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [$clog2(NrVRegs)-1:0]  req_vreg_i,
  input  logic [$clog2(WordsPerVReg)-1:0] req_word_i,
  input  logic [LenWidth-1:0]         req_len_i,
  input  logic                        kill_i,
  output logic [AddrWidth-1:0]        raddr_o,
  output logic                        re_o,
  input  logic [DataWidth-1:0]        rdata_i,
  input  logic                        rvalid_i,
  output logic [DataWidth-1:0]        data_o,
  output logic                        last_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic                        busy_o,
  output logic [31:0]                 conflict_cnt_o
);

  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  vrf_reader_state_e    state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [LenWidth-1:0]  rem_q, rem_d;

  logic                 fifo_full, fifo_empty, fifo_push, pop;
  logic [CntW-1:0]      fifo_cnt;
  logic [DataWidth:0]   fifo_out;

  assign valid_o   = !fifo_empty;
  assign pop       = valid_o && ready_i;
  assign data_o    = fifo_out[DataWidth-1:0];
  assign last_o    = fifo_out[DataWidth];
  assign raddr_o   = addr_q;
  assign busy_o    = (state_q != IDLE) || (fifo_cnt != '0);
  // A grant arriving in a kill cycle is dropped.
  assign fifo_push = re_o && rvalid_i && !kill_i;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    req_ready_o = (state_q == IDLE);
    re_o        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i && req_len_i != '0) begin
          state_d = READ;
          addr_d  = {req_vreg_i, req_word_i};
          rem_d   = req_len_i;
        end
      end
      READ: begin
        // Only issue when the returning word is guaranteed a slot.
        re_o = !fifo_full || pop;
        if (re_o && rvalid_i) begin
          addr_d = addr_q + AddrWidth'(1);
          rem_d  = rem_q - LenWidth'(1);
          if (rem_q == LenWidth'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (kill_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  spatz_vrf_reader_fifo #(
    .Depth (FifoDepth),
    .Width (DataWidth + 1)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (kill_i),
    .push_i  (fifo_push),
    .data_i  ({rem_q == LenWidth'(1), rdata_i}),
    .pop_i   (pop),
    .data_o  (fifo_out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

`ifdef SPATZ_VRF_READER_STATS_EN
  logic [31:0] conflict_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflict_cnt_q <= '0;
    end else if (re_o && !rvalid_i && conflict_cnt_q != '1) begin
      conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;
`else
  assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_spatz_vrf_reader.sv
// Directed and randomized bench for spatz_vrf_reader against a transaction-level reference model.
module tb_spatz_vrf_reader;

  localparam int DEPTH = 2;
  localparam int WPV   = 4;
  localparam int AW    = 7;
  localparam int LW    = 8;
  localparam int DW    = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, req_valid, req_ready, kill, re, rvalid, last, valid, ready, busy;
  logic [4:0]    req_vreg;
  logic [1:0]    req_word;
  logic [LW-1:0] req_len;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata, data;
  logic [31:0]   conflict_cnt;

  spatz_vrf_reader dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_vreg_i     (req_vreg),
    .req_word_i     (req_word),
    .req_len_i      (req_len),
    .kill_i         (kill),
    .raddr_o        (raddr),
    .re_o           (re),
    .rdata_i        (rdata),
    .rvalid_i       (rvalid),
    .data_o         (data),
    .last_o         (last),
    .valid_o        (valid),
    .ready_i        (ready),
    .busy_o         (busy),
    .conflict_cnt_o (conflict_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } ent_t;

  // Reference model: an operand is a list of word addresses; granted words queue up in order.
  bit      m_read = 0;
  int      m_addr = 0;
  int      m_rem  = 0;
  longint  m_cnt  = 0;
  ent_t    m_q[$];

  function automatic logic [DW-1:0] word_of(int a);
    return {4{32'hC0DE_0000 + 32'(a) * 32'h0001_0003}};
  endfunction

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit   exp_valid, pop, re_exp, was_read;
    ent_t e;
    #1;
    rdata = rvalid ? word_of(int'(raddr)) : {4{$urandom}};
    #1;
    exp_valid = (m_q.size() > 0);
    pop       = exp_valid && ready;
    re_exp    = m_read && ((m_q.size() < DEPTH) || pop);
    chk("req_ready", req_ready, !m_read);
    chk("valid", valid, exp_valid);
    if (exp_valid) begin
      chk("data", data, m_q[0].d);
      chk("last", last, m_q[0].l);
    end
    chk("re", re, re_exp);
    if (re_exp) chk("raddr", raddr, m_addr);
    chk("busy", busy, m_read || exp_valid);
`ifdef SPATZ_VRF_READER_STATS_EN
    chk("conflict_cnt", conflict_cnt, m_cnt);
`else
    chk("conflict_cnt", conflict_cnt, 0);
`endif
    @(posedge clk);
    if (rst) begin
      m_read = 0;
      m_q.delete();
      m_cnt = 0;
    end else begin
      if (re_exp && !rvalid && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (kill) begin
        m_read = 0;
        m_q.delete();
      end else begin
        was_read = m_read;
        if (pop) void'(m_q.pop_front());
        if (re_exp && rvalid) begin
          e.d = word_of(m_addr);
          e.l = (m_rem == 1);
          m_q.push_back(e);
          m_addr = (m_addr + 1) % (1 << AW);
          m_rem--;
          if (m_rem == 0) m_read = 0;
        end
        if (!was_read && req_valid && req_len != 0) begin
          m_read = 1;
          m_addr = int'(req_vreg) * WPV + int'(req_word);
          m_rem  = int'(req_len);
        end
      end
    end
    #1;
  endtask

  task automatic reset_chk();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_re", re, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_valid", valid, 0);
    chk("rst_last", last, 0);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_conflict_cnt", conflict_cnt, 0);
  endtask

  task automatic request(int vreg, int word, int len);
    req_valid = 1;
    req_vreg  = 5'(vreg);
    req_word  = 2'(word);
    req_len   = LW'(len);
    step();
    req_valid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rvalid = 1;
    ready  = 1;
    while ((m_read || m_q.size() > 0) && n < 60) begin
      step();
      n++;
    end
    chk("drain_timeout", (n < 60), 1);
  endtask

  initial begin
    longint cnt0;
    rst = 1; req_valid = 0; req_vreg = 0; req_word = 0; req_len = 0;
    kill = 0; rvalid = 0; ready = 0; rdata = '0;
    @(posedge clk);
    #1;
    step();
    step();
    rst = 0;
    reset_chk();

    // Contiguous, register crossing, and address wrap
    rvalid = 1; ready = 1;
    request(3, 0, 4);
    drain();
    request(3, 2, 4);
    drain();
    request(31, 3, 2);
    drain();

    // Conflict stalls: three withheld grants after the second grant
    cnt0 = m_cnt;
    request(3, 0, 4);
    for (int i = 0; i < 8; i++) begin
      rvalid = !(i >= 2 && i <= 4);
      step();
    end
    drain();
    chk("conflict_delta", m_cnt - cnt0, 3);

    // Backpressure: buffer fills, then one pop re-issues a read
    rvalid = 1; ready = 0;
    request(3, 0, 4);
    for (int i = 0; i < 5; i++) step();
    ready = 1;
    step();
    ready = 0;
    for (int i = 0; i < 3; i++) step();
    drain();

    // Kill after two grants, then zero-length request
    request(3, 0, 4);
    step();
    step();
    kill = 1;
    step();
    kill = 0;
    chk("kill_valid", valid, 0);
    chk("kill_re", re, 0);
    chk("kill_req_ready", req_ready, 1);
    chk("kill_busy", busy, 0);
    step();
    request(7, 1, 0);
    chk("len0_re", re, 0);
    chk("len0_busy", busy, 0);
    step();

    // Reset with two words buffered
    ready = 0;
    request(3, 0, 4);
    for (int i = 0; i < 4; i++) step();
    rst = 1;
    step();
    rst = 0;
    reset_chk();
    ready = 1;
    request(3, 0, 4);
    drain();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rvalid    = ($urandom_range(0, 3) != 0);
      ready     = ($urandom_range(0, 3) != 0);
      req_valid = ($urandom_range(0, 2) == 0);
      req_vreg  = 5'($urandom);
      req_word  = 2'($urandom);
      req_len   = LW'($urandom_range(0, 6));
      kill      = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end
    req_valid = 0; kill = 0; rst = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
